// File: rtl/hud_bar_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hud_bar_ctrl
// Brief   : Per-pixel HUD health/score bar selects with frame-latched values,
//           PLAY/LOW/DEAD state machine and sticky game_over.
//           Optional macro HUD_BLINK_EN enables blinking of the LOW-health bar.
// Revision: 1.0  initial release
// ============================================================================
module hud_bar_ctrl #(
  parameter int BAR_X        = 16,
  parameter int HB_Y         = 8,
  parameter int SB_Y         = 20,
  parameter int BAR_H        = 8,
  parameter int LOW_TH       = 64,
  parameter int BLINK_FRAMES = 16,
  parameter int DEAD_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       video_on,
  input  logic [9:0] pixel_row,
  input  logic [9:0] pixel_column,
  input  logic [7:0] health,
  input  logic [7:0] score,
  output logic [1:0] health_disp_ip,
  output logic       score_disp_ip,
  output logic       video_on_d,
  output logic       game_over
);

  localparam logic [10:0] c_BAR_X  = 11'(BAR_X);
  localparam logic [10:0] c_HB_Y0  = 11'(HB_Y);
  localparam logic [10:0] c_HB_Y1  = 11'(HB_Y + BAR_H);
  localparam logic [10:0] c_SB_Y0  = 11'(SB_Y);
  localparam logic [10:0] c_SB_Y1  = 11'(SB_Y + BAR_H);
  localparam logic [8:0]  c_LOW_TH = 9'(LOW_TH);
  localparam int          c_DW     = $clog2(DEAD_FRAMES + 1);
  localparam logic [c_DW-1:0] c_DEAD_MAX = c_DW'(DEAD_FRAMES);

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_LOW  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [c_DW-1:0] dead_cnt_q, dead_cnt_d;
  logic [7:0]      h_s_q, s_s_q;
  logic            hb_win_q, sb_win_q, vo1_q;
  logic [1:0]      hd_q;
  logic            sd_q, vo2_q;

  logic [10:0]     w_row, w_col;
  logic            w_hb_hit, w_sb_hit;
  logic [1:0]      w_class;
  logic            w_blink_on;
  logic            w_hb_en;

  // Shadow copies change only at frame_start so a frame never tears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_s_q <= 8'd0;
      s_s_q <= 8'd0;
    end else if (frame_start) begin
      h_s_q <= health;
      s_s_q <= score;
    end
  end

  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    if (frame_start && (state_q != ST_DEAD)) begin
      if (health == 8'd0) begin
        if (dead_cnt_q != c_DEAD_MAX) begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end else begin
        dead_cnt_d = '0;
      end
      if ((health == 8'd0) && (dead_cnt_d == c_DEAD_MAX)) begin
        state_d = ST_DEAD;
      end else if ((state_q == ST_PLAY) && (health != 8'd0) && ({1'b0, health} < c_LOW_TH)) begin
        state_d = ST_LOW;
      end else if ((state_q == ST_LOW) && ({1'b0, health} >= c_LOW_TH)) begin
        state_d = ST_PLAY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_PLAY;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

`ifdef HUD_BLINK_EN
  localparam int              c_BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_FRAMES - 1);

  logic [c_BW-1:0] blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;

  // Counter only runs while LOW persists across a frame; any other path restarts it with the bar on.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if ((state_q == ST_LOW) && (state_d == ST_LOW)) begin
        if (blink_cnt_q == c_BLINK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end else begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign w_blink_on = phase_q;
`else
  assign w_blink_on = 1'b1;
`endif

  // 11-bit operands keep BAR_X + 2*score from wrapping.
  assign w_row    = {1'b0, pixel_row};
  assign w_col    = {1'b0, pixel_column};
  assign w_hb_hit = (w_row >= c_HB_Y0) && (w_row < c_HB_Y1) &&
                    (w_col >= c_BAR_X) && (w_col < (c_BAR_X + {3'b000, h_s_q}));
  assign w_sb_hit = (w_row >= c_SB_Y0) && (w_row < c_SB_Y1) &&
                    (w_col >= c_BAR_X) && (w_col < (c_BAR_X + {2'b00, s_s_q, 1'b0}));

  always_comb begin
    w_class = 2'b00;
    if (h_s_q >= 8'd128) begin
      w_class = 2'b11;
    end else if ({1'b0, h_s_q} >= c_LOW_TH) begin
      w_class = 2'b10;
    end else if (h_s_q != 8'd0) begin
      w_class = 2'b01;
    end
  end

  assign w_hb_en = (state_q == ST_LOW) ? w_blink_on : (state_q == ST_PLAY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_win_q <= 1'b0;
      sb_win_q <= 1'b0;
      vo1_q    <= 1'b0;
      hd_q     <= 2'b00;
      sd_q     <= 1'b0;
      vo2_q    <= 1'b0;
    end else begin
      hb_win_q <= w_hb_hit;
      sb_win_q <= w_sb_hit;
      vo1_q    <= video_on;
      vo2_q    <= vo1_q;
      sd_q     <= vo1_q & sb_win_q;
      // Score takes priority where the bars would overlap.
      hd_q     <= (vo1_q && hb_win_q && !sb_win_q && w_hb_en) ? w_class : 2'b00;
    end
  end

  assign health_disp_ip = hd_q;
  assign score_disp_ip  = sd_q;
  assign video_on_d     = vo2_q;
  assign game_over      = (state_q == ST_DEAD);

endmodule
`default_nettype wire

// File: tb/tb_hud_bar_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hud_bar_ctrl
// Brief   : Randomized self-checking bench for hud_bar_ctrl against a
//           frame-level reference model (HUD_BLINK_EN aware).
// Revision: 1.0  initial release
// ============================================================================
module tb_hud_bar_ctrl;

  localparam int BAR_X        = 16;
  localparam int HB_Y         = 8;
  localparam int SB_Y         = 20;
  localparam int BAR_H        = 8;
  localparam int LOW_TH       = 64;
  localparam int BLINK_FRAMES = 16;
  localparam int DEAD_FRAMES  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_start;
  logic       video_on;
  logic [9:0] pixel_row;
  logic [9:0] pixel_column;
  logic [7:0] health;
  logic [7:0] score;
  logic [1:0] health_disp_ip;
  logic       score_disp_ip;
  logic       video_on_d;
  logic       game_over;

  hud_bar_ctrl #(
    .BAR_X(BAR_X), .HB_Y(HB_Y), .SB_Y(SB_Y), .BAR_H(BAR_H),
    .LOW_TH(LOW_TH), .BLINK_FRAMES(BLINK_FRAMES), .DEAD_FRAMES(DEAD_FRAMES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .video_on(video_on),
    .pixel_row(pixel_row),
    .pixel_column(pixel_column),
    .health(health),
    .score(score),
    .health_disp_ip(health_disp_ip),
    .score_disp_ip(score_disp_ip),
    .video_on_d(video_on_d),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Frame-level reference model
  int m_h, m_s, m_zero_run, m_low_idx;
  bit m_dead, m_low;

  // Expected-output pipeline, two entries deep
  logic [1:0] ep_h   [2];
  logic       ep_s   [2];
  logic       ep_v   [2];
  bit         ep_ok  [2];
  int         ep_row [2];
  int         ep_col [2];

  function automatic void m_reset();
    m_h = 0; m_s = 0; m_zero_run = 0; m_low_idx = 0;
    m_dead = 1'b0; m_low = 1'b0;
  endfunction

  function automatic void m_frame(input int h, input int s);
    m_h = h;
    m_s = s;
    if (m_dead) return;
    m_zero_run = (h == 0) ? m_zero_run + 1 : 0;
    if (m_zero_run >= DEAD_FRAMES) begin
      m_dead = 1'b1;
      return;
    end
    if (m_low) begin
      if (h >= LOW_TH) m_low = 1'b0;
      else m_low_idx++;
    end else if (h > 0 && h < LOW_TH) begin
      m_low = 1'b1;
      m_low_idx = 0;
    end
  endfunction

  function automatic bit m_phase_on();
`ifdef HUD_BLINK_EN
    return !m_low || (((m_low_idx / BLINK_FRAMES) % 2) == 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_in_score(input int row, input int col);
    return row >= SB_Y && row < SB_Y + BAR_H && col >= BAR_X && col < BAR_X + 2 * m_s;
  endfunction

  function automatic logic [1:0] m_hd(input int row, input int col, input bit vo);
    bit hb;
    hb = row >= HB_Y && row < HB_Y + BAR_H && col >= BAR_X && col < BAR_X + m_h;
    if (!vo || !hb || m_in_score(row, col) || m_dead || !m_phase_on()) return 2'b00;
    if (m_h >= 128) return 2'b11;
    if (m_h >= LOW_TH) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic m_sd(input int row, input int col, input bit vo);
    return vo && m_in_score(row, col);
  endfunction

  function automatic void ep_clear();
    for (int i = 0; i < 2; i++) ep_ok[i] = 1'b0;
  endfunction

  // One pixel clock: check the pixel driven two clocks ago, then drive a new one.
  task automatic step(input int row, input int col, input bit vo, input bit chk);
    @(posedge clk); #1;
    if (ep_ok[1]) begin
      vectors += 3;
      if (health_disp_ip !== ep_h[1]) begin
        miscompares++;
        $display("FAIL health_disp r%0d c%0d: got %b want %b", ep_row[1], ep_col[1], health_disp_ip, ep_h[1]);
      end
      if (score_disp_ip !== ep_s[1]) begin
        miscompares++;
        $display("FAIL score_disp r%0d c%0d: got %b want %b", ep_row[1], ep_col[1], score_disp_ip, ep_s[1]);
      end
      if (video_on_d !== ep_v[1]) begin
        miscompares++;
        $display("FAIL video_on_d r%0d c%0d: got %b want %b", ep_row[1], ep_col[1], video_on_d, ep_v[1]);
      end
    end
    ep_h[1] = ep_h[0]; ep_s[1] = ep_s[0]; ep_v[1] = ep_v[0];
    ep_ok[1] = ep_ok[0]; ep_row[1] = ep_row[0]; ep_col[1] = ep_col[0];
    pixel_row    = 10'(row);
    pixel_column = 10'(col);
    video_on     = vo;
    ep_h[0] = m_hd(row, col, vo);
    ep_s[0] = m_sd(row, col, vo);
    ep_v[0] = vo;
    ep_ok[0] = chk;
    ep_row[0] = row;
    ep_col[0] = col;
  endtask

  task automatic scan(input int row, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) step(row, c, 1'b1, 1'b1);
  endtask

  // Drain pending checks, then pulse frame_start with new health/score.
  task automatic frame(input int h, input int s);
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    health = 8'(h);
    score  = 8'(s);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_frame(h, s);
    vectors++;
    if (game_over !== m_dead) begin
      miscompares++;
      $display("FAIL game_over after frame h=%0d: got %b want %b", h, game_over, m_dead);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    m_reset();
    ep_clear();
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (health_disp_ip !== 2'b00) begin miscompares++; $display("FAIL reset health_disp: got %b want 00", health_disp_ip); end
    if (score_disp_ip !== 1'b0)   begin miscompares++; $display("FAIL reset score_disp: got %b want 0", score_disp_ip); end
    if (video_on_d !== 1'b0)      begin miscompares++; $display("FAIL reset video_on_d: got %b want 0", video_on_d); end
    if (game_over !== 1'b0)       begin miscompares++; $display("FAIL reset game_over: got %b want 0", game_over); end
    reset_n = 1'b1;
    // Shadows are zero: bar rows stay dark before the first frame_start.
    scan(HB_Y, 10, 40);
    scan(SB_Y, 10, 40);
  endtask

  task automatic test_bars();
    frame(200, 50);
    scan(HB_Y, 12, 220);
    scan(HB_Y + BAR_H - 1, 214, 218);
    scan(HB_Y + BAR_H, 14, 20);
    scan(HB_Y - 1, 14, 20);
    scan(SB_Y, 12, 120);
    scan(SB_Y + BAR_H - 1, 113, 118);
    scan(SB_Y + BAR_H, 14, 20);
  endtask

  task automatic test_tear();
    health = 8'd100;
    score  = 8'd5;
    scan(HB_Y, 110, 220);
    scan(SB_Y, 110, 120);
    frame(100, 50);
    scan(HB_Y, 110, 120);
    frame(128, 50);
    scan(HB_Y, 140, 146);
  endtask

  task automatic test_video_on();
    frame(200, 50);
    for (int i = 0; i < 60; i++)
      step((i % 2 == 0) ? HB_Y + 2 : SB_Y + 3, 20 + i, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      frame($urandom_range(1, 255), $urandom_range(0, 255));
      for (int p = 0; p < 40; p++) begin
        if (p == 20) begin
          health = 8'($urandom_range(0, 255));
          score  = 8'($urandom_range(0, 255));
        end
        step($urandom_range(0, 31), $urandom_range(0, 560), ($urandom_range(0, 3) != 0), 1'b1);
      end
    end
  endtask

  task automatic test_blink();
    frame(200, 10);
    for (int f = 0; f < 34; f++) begin
      frame(30, 10);
      step(HB_Y, 15, 1'b1, 1'b1);
      step(HB_Y, 16, 1'b1, 1'b1);
      step(HB_Y, 45, 1'b1, 1'b1);
      step(HB_Y, 46, 1'b1, 1'b1);
      step(SB_Y, 20, 1'b1, 1'b1);
    end
    frame(100, 10);
    scan(HB_Y, 20, 24);
    frame(40, 10);
    scan(HB_Y, 20, 24);
  endtask

  task automatic test_dead();
    frame(0, 10);
    frame(0, 10);
    frame(0, 10);
    frame(10, 10);
    scan(HB_Y, 20, 27);
    for (int i = 0; i < DEAD_FRAMES; i++) frame(0, 30);
    frame(255, 40);
    scan(HB_Y, 14, 20);
    scan(SB_Y, 90, 100);
    frame(100, 40);
    scan(HB_Y, 20, 24);
  endtask

  task automatic test_reset_midframe();
    frame(200, 50);
    scan(HB_Y, 16, 30);
    #2 reset_n = 1'b0;
    #1;
    vectors += 4;
    if (health_disp_ip !== 2'b00) begin miscompares++; $display("FAIL midreset health_disp: got %b want 00", health_disp_ip); end
    if (score_disp_ip !== 1'b0)   begin miscompares++; $display("FAIL midreset score_disp: got %b want 0", score_disp_ip); end
    if (video_on_d !== 1'b0)      begin miscompares++; $display("FAIL midreset video_on_d: got %b want 0", video_on_d); end
    if (game_over !== 1'b0)       begin miscompares++; $display("FAIL midreset game_over: got %b want 0", game_over); end
    m_reset();
    ep_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    scan(HB_Y, 14, 40);
    scan(SB_Y, 14, 40);
    frame(30, 20);
    scan(HB_Y, 40, 50);
    scan(SB_Y, 50, 60);
  endtask

  initial begin
    reset_n = 1'b1; frame_start = 1'b0; video_on = 1'b0;
    pixel_row = '0; pixel_column = '0; health = '0; score = '0;
    for (int i = 0; i < 2; i++) begin
      ep_h[i] = 2'b00; ep_s[i] = 1'b0; ep_v[i] = 1'b0;
      ep_ok[i] = 1'b0; ep_row[i] = 0; ep_col[i] = 0;
    end
    m_reset();
    test_reset();
    test_bars();
    test_tear();
    test_video_on();
    test_random();
    test_blink();
    test_dead();
    test_reset_midframe();
    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
